// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared types, defaults and round-robin pick for mult_share_arbiter
package mult_share_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_RESP = 2'd2} state_t;
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;
  // Searches ptr, ptr+1, ... mod n; the descending loop lets the nearest hit win.
  function automatic pick_t rr_pick(input logic [7:0] vld, input int ptr, input int n);
    pick_t r;
    int j;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        j = ptr + i;
        if (j >= n) j = j - n;
        if (vld[j]) r = '{found: 1'b1, idx: 3'(j)};
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/mult_share_arbiter_mult_core_signed.sv
// mult_core_signed: combinational WIDTH x WIDTH two's-complement multiplier
module mult_core_signed #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);
  assign p = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one signed multiplier among N_REQ requesters
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]     rsp_product,
  output logic                   busy
);
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, op_id, win_id;
  logic [WIDTH-1:0] op_a, op_b;
  logic [2*WIDTH-1:0] product;
  pick_t pick;
  logic grant;
  assign pick   = rr_pick(8'(req_valid), int'(rr_ptr), N_REQ);
  assign win_id = ID_W'(pick.idx);
  assign grant  = rst_n && pick.found && (state == ST_IDLE || (state == ST_RESP && rsp_ready));
  assign busy   = state != ST_IDLE;
  always_comb begin
    req_ready = grant ? N_REQ'(1) << win_id : '0;
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = pick.found ? ST_CALC : ST_IDLE;
      ST_CALC: state_nx = ST_RESP;
      ST_RESP: state_nx = rsp_ready ? (pick.found ? ST_CALC : ST_IDLE) : ST_RESP;
      default: state_nx = ST_IDLE;
    endcase
  end
  mult_core_signed #(.WIDTH(WIDTH)) u_core (
    .a(op_a),
    .b(op_b),
    .p(product)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_id       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        op_a   <= req_a[win_id*WIDTH +: WIDTH];
        op_b   <= req_b[win_id*WIDTH +: WIDTH];
        op_id  <= win_id;
        rr_ptr <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
      end
      if (state == ST_CALC) begin
        rsp_product <= product;
        rsp_id      <= op_id;
        rsp_valid   <= 1'b1;
      end else if (state == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed and random checks against a transaction-level reference model
module tb_mult_share_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*8-1:0] req_a = '0;
  logic [N*8-1:0] req_b = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [1:0] rsp_id;
  logic [15:0] rsp_product;
  logic busy;
  mult_share_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    int          id;
    logic [15:0] p;
    int          g;
  } txn_t;
  txn_t q[$];
  int gl[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, ptr = 0, n_rsp = 0;
  logic [N-1:0] pend = '0, auto_re = '0;
  logic [7:0] opa[N], opb[N];
  logic [15:0] last_prod;
  int last_id;
  bit rnd = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    int x, y;
    x = $signed(a);
    y = $signed(b);
    return 16'(x * y);
  endfunction
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_a[i*8 +: 8] = opa[i];
      req_b[i*8 +: 8] = opb[i];
    end
  endtask
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    pend[i] = 1'b1;
    opa[i] = a;
    opb[i] = b;
    drive();
  endtask
  // One clock: check outputs at negedge, advance the model, drive new inputs after posedge.
  task automatic step();
    logic hs;
    logic [N-1:0] exp_rdy;
    int w, k;
    @(negedge clk);
    hs = rsp_valid && rsp_ready;
    chk("rsp_valid", rsp_valid, q.size() > 0 && cyc - q[0].g >= 2);
    if (q.size() > 0 && rsp_valid) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_product", rsp_product, q[0].p);
    end
    chk("busy", busy, q.size() != 0);
    w = -1;
    if (|req_valid && (q.size() == 0 || hs))
      for (int j = 0; j < N; j++) begin
        k = (ptr + j) % N;
        if (w < 0 && req_valid[k]) w = k;
      end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (hs) begin
      last_prod = rsp_product;
      last_id = rsp_id;
      n_rsp++;
      void'(q.pop_front());
    end
    if (w >= 0) begin
      q.push_back('{w, prod(opa[w], opb[w]), cyc});
      ptr = (w + 1) % N;
      gl.push_back(w);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (w >= 0) pend[w] = auto_re[w];
    if (rnd) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          opa[i] = 8'($urandom);
          opb[i] = 8'($urandom);
        end
      rsp_ready = $urandom_range(2) != 0;
    end
    drive();
  endtask
  task automatic run_idle();
    int n = 0;
    while ((q.size() > 0 || |pend) && n < 200) begin
      step();
      n++;
    end
    chk("idle_timeout", n < 200, 1);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    pend = '0;
    auto_re = '0;
    rsp_ready = 1'b0;
    drive();
    q.delete();
    ptr = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic single(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e, input string tag);
    rsp_ready = 1'b1;
    set_req(0, a, b);
    run_idle();
    chk(tag, last_prod, e);
  endtask
  initial begin
    int n0;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_product", rsp_product, 0);
    chk("rst_rsp_id", rsp_id, 0);
    do_reset();
    single(8'hE5, 8'h95, 16'h0B49, "prod_e5_95");
    chk("id_single", last_id, 0);
    single(8'hFB, 8'h04, 16'hFFEC, "prod_fb_04");
    single(8'h05, 8'h04, 16'h0014, "prod_05_04");
    single(8'h80, 8'h80, 16'h4000, "prod_80_80");
    single(8'h7F, 8'h80, 16'hC080, "prod_7f_80");
    do_reset();
    gl.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'(i + 1), 8'd2);
    run_idle();
    chk("fair_count", gl.size(), 4);
    for (int i = 0; i < 4 && i < gl.size(); i++) chk("fair_order", gl[i], i);
    chk("fair_last_prod", last_prod, 16'd8);
    set_req(0, 8'd9, 8'd3);
    set_req(2, 8'd7, 8'd3);
    run_idle();
    chk("wrap_first", gl.size() > 4 ? gl[4] : -1, 0);
    chk("wrap_second", gl.size() > 5 ? gl[5] : -1, 2);
    rsp_ready = 1'b0;
    set_req(0, 8'h11, 8'h22);
    repeat (3) step();
    chk("bp_valid", rsp_valid, 1);
    set_req(1, 8'hF0, 8'h0F);
    repeat (5) begin
      step();
      chk("bp_hold_rdy", req_ready, 0);
    end
    gl.delete();
    rsp_ready = 1'b1;
    run_idle();
    chk("bp_grant1", gl.size() > 0 ? gl[0] : -1, 1);
    chk("bp_prod1", last_prod, prod(8'hF0, 8'h0F));
    set_req(0, 8'h33, 8'h44);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rr_ptr", dut.rr_ptr, 0);
    chk("arst_req_ready", req_ready, 0);
    q.delete();
    ptr = 0;
    pend = '0;
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) step();
    gl.delete();
    auto_re[2] = 1'b1;
    auto_re[3] = 1'b1;
    set_req(2, 8'h12, 8'hFD);
    set_req(3, 8'h81, 8'h7E);
    repeat (4) step();
    n0 = n_rsp;
    repeat (20) step();
    chk("thru_count", n_rsp - n0, 10);
    for (int i = 1; i < gl.size(); i++) chk("thru_alt", gl[i] != gl[i-1], 1);
    auto_re = '0;
    run_idle();
    rnd = 1;
    repeat (600) step();
    rnd = 0;
    rsp_ready = 1'b1;
    run_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
